shutdown_sense_scan: RTL and testbench

Parametrised, time-multiplexed shutdown-sense scanner. Drives an external analog/digital mux select, waits a settle time, then samples a single shared sense pin for each channel in turn. Each channel has a consecutive-sample fault filter and a sticky latched fault bit, with per-channel mask and clear. The block sits between the board-level shutdown sense mux and the system fault/interlock logic.

---
 rtl/shutdown_sense_scan_if.sv | 40 ++++
 rtl/shutdown_sense_scan.sv | 154 +++++++++++++++
 tb/tb_shutdown_sense_scan.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shutdown_sense_scan_if.sv
// -----------------------------------------------------------------------------
// shutdown_sense_scan_if
//   Bundles the control, sense-mux and fault-report signals of the
//   shutdown-sense scanner.
//   master : system side. Drives enable/mask/clear and the shared sense pin,
//            and observes the mux select and the fault outputs.
//   slave  : scanner side, the mirror image of master.
// Signals:
//   enable             scanning enabled
//   mask[N_CH]         1 = channel ignored by the filter
//   clear[N_CH]        per-channel clear strobe for the sticky bit and filter
//   shutdown_sense_pin shared asynchronous sense input from the mux
//   shutdown_sense_sel mux select, registered
//   shutdown_sense     sticky latched fault bits
//   any_shutdown       registered OR of shutdown_sense
//   scan_done          one-cycle pulse after the last channel is sampled
// -----------------------------------------------------------------------------
interface shutdown_sense_scan_if #(
  parameter int N_CH  = 8,
  parameter int SEL_W = 3
);
  logic             enable;
  logic [N_CH-1:0]  mask;
  logic [N_CH-1:0]  clear;
  logic             shutdown_sense_pin;
  logic [SEL_W-1:0] shutdown_sense_sel;
  logic [N_CH-1:0]  shutdown_sense;
  logic             any_shutdown;
  logic             scan_done;

  modport master (
    output enable, mask, clear, shutdown_sense_pin,
    input  shutdown_sense_sel, shutdown_sense, any_shutdown, scan_done
  );

  modport slave (
    input  enable, mask, clear, shutdown_sense_pin,
    output shutdown_sense_sel, shutdown_sense, any_shutdown, scan_done
  );
endinterface

// File: rtl/shutdown_sense_scan.sv
// -----------------------------------------------------------------------------
// shutdown_sense_scan
//   Time-multiplexed shutdown-sense scanner. Steps an external mux select
//   through N_CH channels, lets each selection settle for SETTLE_CYCLES
//   cycles, then samples the shared sense pin once. Each channel has a
//   consecutive-sample filter (FILTER_COUNT hits on successive scans) that
//   sets a sticky fault bit, with per-channel mask and clear.
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset
//   bus  shutdown_sense_scan_if.slave (control, sense mux, fault outputs)
// -----------------------------------------------------------------------------
module shutdown_sense_scan #(
  parameter int N_CH          = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int FILTER_COUNT  = 3,
  parameter int ACTIVE_HIGH   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  shutdown_sense_scan_if.slave bus
);

  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int CNT_W = $clog2(FILTER_COUNT + 1);

  localparam logic [SEL_W-1:0] LAST_CH     = SEL_W'(N_CH - 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(FILTER_COUNT);
  // Pin level that means "no fault"; the synchroniser resets to it so a
  // reset never looks like a fault on the first sample.
  localparam logic             PIN_IDLE    = (ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE
  } state_e;

  state_e           state_q;
  logic [SEL_W-1:0] sel_q;
  logic [SET_W-1:0] settle_q;
  logic             scan_done_q;
  logic             sync1_q, sync2_q;
  logic             fault;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [N_CH-1:0]  sense_q, sense_d;
  logic             any_q;

  // Two-flop synchroniser for the asynchronous pin, then normalise so that
  // fault = 1 regardless of pin polarity.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of the others; sync2_q must see the old sync1_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= PIN_IDLE;
      sync2_q <= PIN_IDLE;
    end else begin
      sync1_q <= bus.shutdown_sense_pin;
      sync2_q <= sync1_q;
    end
  end

  assign fault = (ACTIVE_HIGH != 0) ? sync2_q : ~sync2_q;

  // Scan sequencer. The settle window covers the synchroniser latency, so
  // the value sampled in ST_SAMPLE belongs to the channel on sel_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      settle_q    <= '0;
      scan_done_q <= 1'b0;
    end else begin
      scan_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.enable) begin
            state_q  <= ST_SETTLE;
            settle_q <= '0;
          end
        end
        ST_SETTLE: begin
          // Abort leaves sel_q untouched so scanning resumes on the same
          // channel with a full settle window.
          if (!bus.enable) begin
            state_q <= ST_IDLE;
          end else if (settle_q == SETTLE_LAST) begin
            state_q <= ST_SAMPLE;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        ST_SAMPLE: begin
          // Explicit wrap so non-power-of-two channel counts never select
          // a nonexistent channel.
          sel_q       <= (sel_q == LAST_CH) ? '0 : sel_q + 1'b1;
          scan_done_q <= (sel_q == LAST_CH);
          settle_q    <= '0;
          state_q     <= bus.enable ? ST_SETTLE : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Per-channel filter. Counters persist across scans, so "consecutive"
  // means consecutive visits to that channel. Clear is applied last so it
  // overrides a set in the same cycle.
  // NOTE: every always_comb output gets a default first; without it a path
  // that skips an assignment would infer a latch.
  always_comb begin
    cnt_d   = cnt_q;
    sense_d = sense_q;
    for (int i = 0; i < N_CH; i++) begin
      if (state_q == ST_SAMPLE && sel_q == SEL_W'(i)) begin
        if (bus.mask[i]) begin
          cnt_d[i] = '0;
        end else if (fault) begin
          if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
          if (cnt_d[i] == CNT_MAX) sense_d[i] = 1'b1;
        end else begin
          cnt_d[i] = '0;
        end
      end
      if (bus.clear[i]) begin
        cnt_d[i]   = '0;
        sense_d[i] = 1'b0;
      end
    end
  end

  // NOTE: the counter array is a handful of flops, not a RAM, so it is
  // reset with the rest of the state; a true memory would not be.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '{default: '0};
      sense_q <= '0;
      any_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sense_q <= sense_d;
      any_q   <= |sense_q;
    end
  end

  assign bus.shutdown_sense_sel = sel_q;
  assign bus.shutdown_sense     = sense_q;
  assign bus.any_shutdown       = any_q;
  assign bus.scan_done          = scan_done_q;

endmodule

// File: tb/tb_shutdown_sense_scan.sv
// -----------------------------------------------------------------------------
// tb_shutdown_sense_scan
//   Bench for shutdown_sense_scan. dut_a: 8 channels, active-high pin.
//   dut_b: 5 channels, active-low pin. Each sense pin is driven by a mux
//   model that reflects a per-channel fault map on the current select.
//   Expected sticky-bit values are queued when the fault stimulus is set
//   and compared after the DUT samples the channel.
// -----------------------------------------------------------------------------
module tb_shutdown_sense_scan;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] fault_map_a = '0;
  logic [7:0] fault_map_b = '0;

  typedef struct {
    string      name;
    logic [7:0] sense;
  } exp_t;
  exp_t sb_q[$];

  shutdown_sense_scan_if #(.N_CH(8), .SEL_W(3)) bus_a ();
  shutdown_sense_scan_if #(.N_CH(5), .SEL_W(3)) bus_b ();

  shutdown_sense_scan #(.N_CH(8), .SETTLE_CYCLES(4), .FILTER_COUNT(3), .ACTIVE_HIGH(1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  shutdown_sense_scan #(.N_CH(5), .SETTLE_CYCLES(4), .FILTER_COUNT(3), .ACTIVE_HIGH(0))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // External mux models: faulted channel drives the fault level.
  assign bus_a.shutdown_sense_pin = fault_map_a[bus_a.shutdown_sense_sel];
  assign bus_b.shutdown_sense_pin = ~fault_map_b[bus_b.shutdown_sense_sel];

  function automatic int cur_sel(input bit b);
    return b ? int'(bus_b.shutdown_sense_sel) : int'(bus_a.shutdown_sense_sel);
  endfunction

  function automatic logic [7:0] cur_sense(input bit b);
    return b ? {3'b000, bus_b.shutdown_sense} : bus_a.shutdown_sense;
  endfunction

  function automatic logic cur_any(input bit b);
    return b ? bus_b.any_shutdown : bus_a.any_shutdown;
  endfunction

  function automatic logic cur_done(input bit b);
    return b ? bus_b.scan_done : bus_a.scan_done;
  endfunction

  function automatic void push(input string n, input logic [7:0] s);
    exp_t e;
    e.name  = n;
    e.sense = s;
    sb_q.push_back(e);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus_a.enable = 1'b0; bus_a.mask = '0; bus_a.clear = '0;
    bus_b.enable = 1'b0; bus_b.mask = '0; bus_b.clear = '0;
    fault_map_a = '0;
    fault_map_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) until select shows channel ch.
  task automatic wait_arrive(input bit b, input int ch, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (cur_sel(b) == ch) ok = 1'b1;
    end
  endtask

  // Waits (bounded) until channel ch has been visited and left, i.e. its
  // sample was just taken; returns the sticky bits at that point.
  task automatic wait_sample(input bit b, input int ch, output bit ok, output logic [7:0] act);
    bit seen;
    seen = 1'b0;
    ok   = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (!seen) seen = (cur_sel(b) == ch);
      else if (cur_sel(b) != ch) ok = 1'b1;
    end
    act = cur_sense(b);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.enable = 1'b1; bus_a.mask = '0; bus_a.clear = '0;
    bus_b.enable = 1'b1; bus_b.mask = '0; bus_b.clear = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus_a.shutdown_sense_sel !== 3'd0) begin errors++; $display("FAIL reset_sel_a: got %0d expected 0", bus_a.shutdown_sense_sel); end
    checks++;
    if (bus_a.shutdown_sense !== 8'h00) begin errors++; $display("FAIL reset_sense_a: got %h expected 00", bus_a.shutdown_sense); end
    checks++;
    if (bus_a.any_shutdown !== 1'b0) begin errors++; $display("FAIL reset_any_a: got %b expected 0", bus_a.any_shutdown); end
    checks++;
    if (bus_a.scan_done !== 1'b0) begin errors++; $display("FAIL reset_done_a: got %b expected 0", bus_a.scan_done); end
    checks++;
    if (bus_b.shutdown_sense_sel !== 3'd0) begin errors++; $display("FAIL reset_sel_b: got %0d expected 0", bus_b.shutdown_sense_sel); end
    checks++;
    if (bus_b.shutdown_sense !== 5'b00000) begin errors++; $display("FAIL reset_sense_b: got %b expected 00000", bus_b.shutdown_sense); end
  endtask

  // Clean scan: checks select stepping/wrap, 5-cycle dwell, scan_done
  // position and period, and that no fault appears.
  task automatic test_scan_timing(input bit b, input int nch, input int ncyc, input int exp_done);
    int prev, dwell, changes, last_done, dones, cur, max_sel;
    bit nonzero;
    do_reset();
    if (b) bus_b.enable = 1'b1; else bus_a.enable = 1'b1;
    prev = 0; dwell = 0; changes = 0; last_done = -1; dones = 0; max_sel = 0; nonzero = 1'b0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge clk);
      cur = cur_sel(b);
      dwell++;
      if (cur > max_sel) max_sel = cur;
      if (cur_sense(b) !== 8'h00 || cur_any(b) !== 1'b0) nonzero = 1'b1;
      if (cur_done(b) === 1'b1) begin
        dones++;
        checks++;
        if (prev != nch - 1 || cur != 0) begin
          errors++; $display("FAIL scan_done_pos[%0d]: sel %0d->%0d, expected %0d->0", b, prev, cur, nch - 1);
        end
        if (last_done >= 0) begin
          checks++;
          if (cyc - last_done != nch * 5) begin
            errors++; $display("FAIL scan_period[%0d]: got %0d expected %0d", b, cyc - last_done, nch * 5);
          end
        end
        last_done = cyc;
      end
      if (cur != prev) begin
        checks++;
        if (cur != (prev + 1) % nch) begin
          errors++; $display("FAIL sel_step[%0d]: %0d->%0d expected %0d", b, prev, cur, (prev + 1) % nch);
        end
        if (changes > 0) begin
          checks++;
          if (dwell != 5) begin errors++; $display("FAIL dwell[%0d] ch%0d: got %0d expected 5", b, prev, dwell); end
        end
        changes++;
        dwell = 0;
        prev  = cur;
      end
    end
    checks++;
    if (max_sel != nch - 1) begin errors++; $display("FAIL sel_max[%0d]: got %0d expected %0d", b, max_sel, nch - 1); end
    checks++;
    if (dones != exp_done) begin errors++; $display("FAIL scan_done_count[%0d]: got %0d expected %0d", b, dones, exp_done); end
    checks++;
    if (nonzero) begin errors++; $display("FAIL clean_scan_faults[%0d]: sense/any nonzero, expected 0", b); end
  endtask

  task automatic test_filter_latch();
    bit ok; logic [7:0] act; exp_t e;
    do_reset();
    fault_map_a = 8'h08;
    push("latch_scan1", 8'h00); push("latch_scan2", 8'h00); push("latch_scan3", 8'h08);
    bus_a.enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_sample(1'b0, 3, ok, act);
      e = sb_q.pop_front(); checks++;
      if (!ok || act !== e.sense) begin errors++; $display("FAIL %s: sense=%h timeout=%0d expected %h", e.name, act, !ok, e.sense); end
    end
    checks++;
    if (bus_a.any_shutdown !== 1'b0) begin errors++; $display("FAIL any_delay: got %b expected 0 in latch cycle", bus_a.any_shutdown); end
    @(negedge clk);
    checks++;
    if (bus_a.any_shutdown !== 1'b1) begin errors++; $display("FAIL any_set: got %b expected 1", bus_a.any_shutdown); end
    fault_map_a = 8'h00;
    push("sticky_scan4", 8'h08); push("sticky_scan5", 8'h08);
    for (int k = 0; k < 2; k++) begin
      wait_sample(1'b0, 3, ok, act);
      e = sb_q.pop_front(); checks++;
      if (!ok || act !== e.sense) begin errors++; $display("FAIL %s: sense=%h timeout=%0d expected %h", e.name, act, !ok, e.sense); end
    end
  endtask

  task automatic test_intermittent();
    bit ok; logic [7:0] act; exp_t e;
    bit         fm  [6] = '{1, 1, 0, 1, 1, 1};
    logic [7:0] exp [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20};
    do_reset();
    bus_a.enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      fault_map_a = fm[k] ? 8'h20 : 8'h00;
      push($sformatf("intermittent_scan%0d", k + 1), exp[k]);
      wait_sample(1'b0, 5, ok, act);
      e = sb_q.pop_front(); checks++;
      if (!ok || act !== e.sense) begin errors++; $display("FAIL %s: sense=%h timeout=%0d expected %h", e.name, act, !ok, e.sense); end
    end
  endtask

  task automatic test_mask_clear();
    bit ok, ok_arr; logic [7:0] act; exp_t e;
    logic [7:0] exp [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08};
    do_reset();
    bus_a.mask  = 8'h04;
    fault_map_a = 8'h0C;
    bus_a.enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin
        // Hold clear over the whole visit, including the would-latch sample.
        wait_arrive(1'b0, 3, ok_arr);
        checks++;
        if (!ok_arr) begin errors++; $display("FAIL clear_arrive: sel never reached 3 (timeout)"); end
        bus_a.clear = 8'h08;
      end
      push($sformatf("mask_clear_scan%0d", k + 1), exp[k]);
      wait_sample(1'b0, 3, ok, act);
      bus_a.clear = 8'h00;
      e = sb_q.pop_front(); checks++;
      if (!ok || act !== e.sense) begin errors++; $display("FAIL %s: sense=%h timeout=%0d expected %h", e.name, act, !ok, e.sense); end
    end
    bus_a.mask = 8'h0C;
    push("mask_keeps_bit", 8'h08);
    wait_sample(1'b0, 3, ok, act);
    e = sb_q.pop_front(); checks++;
    if (!ok || act !== e.sense) begin errors++; $display("FAIL %s: sense=%h timeout=%0d expected %h", e.name, act, !ok, e.sense); end
  endtask

  task automatic test_abort();
    bit ok; logic [7:0] act; exp_t e;
    do_reset();
    fault_map_a = 8'h40;
    bus_a.enable = 1'b1;
    push("abort_pre1", 8'h00); push("abort_pre2", 8'h00);
    for (int k = 0; k < 2; k++) begin
      wait_sample(1'b0, 6, ok, act);
      e = sb_q.pop_front(); checks++;
      if (!ok || act !== e.sense) begin errors++; $display("FAIL %s: sense=%h timeout=%0d expected %h", e.name, act, !ok, e.sense); end
    end
    // A third faulted sample would latch, so a sample taken during the
    // aborted settle would show up as bit 6.
    wait_arrive(1'b0, 6, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_arrive: sel never reached 6 (timeout)"); end
    repeat (2) @(negedge clk);
    bus_a.enable = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (bus_a.shutdown_sense_sel !== 3'd6) begin errors++; $display("FAIL abort_sel_hold: got %0d expected 6", bus_a.shutdown_sense_sel); end
    checks++;
    if (bus_a.shutdown_sense !== 8'h00) begin errors++; $display("FAIL abort_no_sample: sense=%h expected 00", bus_a.shutdown_sense); end
    fault_map_a = 8'h00;
    bus_a.enable = 1'b1;
    push("abort_resume", 8'h00);
    wait_sample(1'b0, 6, ok, act);
    e = sb_q.pop_front(); checks++;
    if (!ok || act !== e.sense) begin errors++; $display("FAIL %s: sense=%h timeout=%0d expected %h", e.name, act, !ok, e.sense); end
    checks++;
    if (bus_a.shutdown_sense_sel !== 3'd7) begin errors++; $display("FAIL abort_resume_next: sel=%0d expected 7", bus_a.shutdown_sense_sel); end
  endtask

  task automatic test_reset_mid();
    bit ok; logic [7:0] act; exp_t e; int n;
    do_reset();
    fault_map_a = 8'h02;
    bus_a.enable = 1'b1;
    push("pre_rst_scan1", 8'h00); push("pre_rst_scan2", 8'h00); push("pre_rst_scan3", 8'h02);
    for (int k = 0; k < 3; k++) begin
      wait_sample(1'b0, 1, ok, act);
      e = sb_q.pop_front(); checks++;
      if (!ok || act !== e.sense) begin errors++; $display("FAIL %s: sense=%h timeout=%0d expected %h", e.name, act, !ok, e.sense); end
    end
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_a.shutdown_sense !== 8'h00) begin errors++; $display("FAIL rst_mid_sense: got %h expected 00", bus_a.shutdown_sense); end
    checks++;
    if (bus_a.any_shutdown !== 1'b0) begin errors++; $display("FAIL rst_mid_any: got %b expected 0", bus_a.any_shutdown); end
    checks++;
    if (bus_a.shutdown_sense_sel !== 3'd0) begin errors++; $display("FAIL rst_mid_sel: got %0d expected 0", bus_a.shutdown_sense_sel); end
    checks++;
    if (bus_a.scan_done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b expected 0", bus_a.scan_done); end
    fault_map_a = 8'h00;
    rst = 1'b0;
    // From release: one IDLE cycle, four settle cycles, then the sample.
    n = 0;
    ok = 1'b0;
    while (n < 100 && !ok) begin
      @(negedge clk);
      n++;
      if (bus_a.shutdown_sense_sel !== 3'd0) ok = 1'b1;
    end
    checks++;
    if (!ok || bus_a.shutdown_sense_sel !== 3'd1 || n != 6) begin
      errors++; $display("FAIL rst_restart: sel=%0d after %0d cycles, expected sel=1 after 6", bus_a.shutdown_sense_sel, n);
    end
  endtask

  task automatic test_n5_active_low();
    bit ok; logic [7:0] act; exp_t e;
    test_scan_timing(1'b1, 5, 60, 2);
    fault_map_b = 8'h02;
    push("n5_low_scan1", 8'h00); push("n5_low_scan2", 8'h00); push("n5_low_scan3", 8'h02);
    for (int k = 0; k < 3; k++) begin
      wait_sample(1'b1, 1, ok, act);
      e = sb_q.pop_front(); checks++;
      if (!ok || act !== e.sense) begin errors++; $display("FAIL %s: sense=%h timeout=%0d expected %h", e.name, act, !ok, e.sense); end
    end
    @(negedge clk);
    checks++;
    if (bus_b.any_shutdown !== 1'b1) begin errors++; $display("FAIL n5_any: got %b expected 1", bus_b.any_shutdown); end
  endtask

  initial begin
    test_reset();
    test_scan_timing(1'b0, 8, 100, 2);
    test_filter_latch();
    test_intermittent();
    test_mask_clear();
    test_abort();
    test_reset_mid();
    test_n5_active_low();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
